// File: rtl/shifttaps_stream_ctrl_if.sv
// Stream bundle between the sample source, the shifttaps sequencer and the downstream window reader.
// With SHIFTTAPS_CTRL_FILLCNT_EN defined the bundle also carries the o_fill level.
interface shifttaps_stream_ctrl_if #(
  parameter int WIDTH = 16,
  parameter int CW    = 13
);
  logic [WIDTH-1:0] i_dat;
  logic             i_val;
  logic             i_rdy;
  logic             i_flush;
  logic             sr_clkena;
  logic [WIDTH-1:0] sr_idat;
  logic             o_val;
  logic             o_rdy;
  logic             o_primed;
  logic             o_busy;
`ifdef SHIFTTAPS_CTRL_FILLCNT_EN
  logic [CW-1:0]    o_fill;

  modport master (
    output i_dat, i_val, i_flush, o_rdy,
    input  i_rdy, sr_clkena, sr_idat, o_val, o_primed, o_busy, o_fill
  );
  modport slave (
    input  i_dat, i_val, i_flush, o_rdy,
    output i_rdy, sr_clkena, sr_idat, o_val, o_primed, o_busy, o_fill
  );
`else
  modport master (
    output i_dat, i_val, i_flush, o_rdy,
    input  i_rdy, sr_clkena, sr_idat, o_val, o_primed, o_busy
  );
  modport slave (
    input  i_dat, i_val, i_flush, o_rdy,
    output i_rdy, sr_clkena, sr_idat, o_val, o_primed, o_busy
  );
`endif
endinterface

// File: rtl/shifttaps_stream_ctrl.sv
// Stream sequencer for a memory-based multi-tap shift register: shift strobes, fill tracking,
// window qualification and zero-flush. Optional o_fill port under SHIFTTAPS_CTRL_FILLCNT_EN.
//
// state | meaning
// RUN   | accept samples, track fill level, qualify taps with o_val
// FLUSH | shift FILL zeros into the delay line, input blocked
module shifttaps_stream_ctrl #(
  parameter int WIDTH    = 16,
  parameter int DISTANCE = 64,
  parameter int COUNT    = 101
) (
  input  logic                  reset,
  input  logic                  clk,
  shifttaps_stream_ctrl_if.slave s
);
  localparam int FILL = DISTANCE * COUNT;
  localparam int CW   = $clog2(FILL + 1);
  localparam logic [CW-1:0] FILL_C  = CW'(FILL);
  localparam logic [CW-1:0] FILL_M1 = CW'(FILL - 1);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;

  state_t           state, state_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [CW-1:0]    fcnt, fcnt_n;
  logic             o_val_q, o_val_n;
  logic             rdy;
  logic             shift;
  logic             clkena;
  logic [WIDTH-1:0] idat;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= RUN;
      cnt     <= '0;
      fcnt    <= '0;
      o_val_q <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      fcnt    <= fcnt_n;
      o_val_q <= o_val_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    fcnt_n  = fcnt;
    o_val_n = o_val_q;
    rdy     = 1'b0;
    shift   = 1'b0;
    clkena  = 1'b0;
    idat    = s.i_dat;
    case (state)
      RUN: begin
        // Reset gates ready so nothing looks acceptable while the block is held in reset.
        rdy    = !reset && !s.i_flush && (!o_val_q || s.o_rdy);
        shift  = s.i_val && rdy;
        clkena = shift;
        if (shift) begin
          cnt_n = (cnt == FILL_C) ? FILL_C : cnt + ONE_C;
        end
        // Comparing against FILL-1 avoids overflowing cnt+1 when FILL+1 is a power of two.
        if (shift && (cnt >= FILL_M1)) begin
          o_val_n = 1'b1;
        end else if (o_val_q && s.o_rdy) begin
          o_val_n = 1'b0;
        end
        if (s.i_flush) begin
          o_val_n = 1'b0;
          fcnt_n  = '0;
          state_n = FLUSH;
        end
      end
      FLUSH: begin
        clkena  = 1'b1;
        idat    = '0;
        o_val_n = 1'b0;
        fcnt_n  = fcnt + ONE_C;
        if (fcnt == FILL_M1) begin
          cnt_n   = '0;
          state_n = RUN;
        end
      end
      default: state_n = RUN;
    endcase
  end

  assign s.i_rdy     = rdy;
  assign s.sr_clkena = clkena;
  assign s.sr_idat   = idat;
  assign s.o_val     = o_val_q;
  assign s.o_primed  = (cnt == FILL_C);
  assign s.o_busy    = (state == FLUSH);
`ifdef SHIFTTAPS_CTRL_FILLCNT_EN
  assign s.o_fill    = cnt;
`endif

endmodule

// File: tb/tb_shifttaps_stream_ctrl.sv
// Directed bench for shifttaps_stream_ctrl paired with a behavioural shifttaps (WIDTH=8, DISTANCE=2, COUNT=3).
// Build with SHIFTTAPS_CTRL_FILLCNT_EN to also check o_fill.
module tb_shifttaps_stream_ctrl;
  localparam int WIDTH    = 8;
  localparam int DISTANCE = 2;
  localparam int COUNT    = 3;
  localparam int FILL     = DISTANCE * COUNT;
  localparam int CW       = $clog2(FILL + 1);

  logic reset;
  logic clk;
  int   errors = 0;
  int   checks = 0;

  shifttaps_stream_ctrl_if #(.WIDTH(WIDTH), .CW(CW)) bus ();

  shifttaps_stream_ctrl #(.WIDTH(WIDTH), .DISTANCE(DISTANCE), .COUNT(COUNT)) dut (
    .reset (reset),
    .clk   (clk),
    .s     (bus.slave)
  );

  // Paired shift register: sr[0] newest; taps[k] = sr[DISTANCE*(k+1)-1], odat = oldest.
  logic [WIDTH-1:0] sr [0:FILL-1];
  always @(posedge clk) begin
    if (bus.sr_clkena) begin
      for (int i = FILL - 1; i > 0; i--) sr[i] <= sr[i-1];
      sr[0] <= bus.sr_idat;
    end
  end

  function automatic logic [WIDTH-1:0] tap(input int k);
    return sr[DISTANCE*(k+1)-1];
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk_taps(input string tag, input int t0, input int t1, input int t2, input int od);
    chk({tag, "_tap0"}, 32'(tap(0)), t0);
    chk({tag, "_tap1"}, 32'(tap(1)), t1);
    chk({tag, "_tap2"}, 32'(tap(2)), t2);
    chk({tag, "_odat"}, 32'(sr[FILL-1]), od);
  endtask

  task automatic chk_fill(input string tag, input int exp);
`ifdef SHIFTTAPS_CTRL_FILLCNT_EN
    chk(tag, 32'(bus.o_fill), exp);
`else
    if (exp < 0) $display("unexpected negative fill %0d at %s", exp, tag);
`endif
  endtask

  // Push a sample while downstream is ready; o_val must stay low until the last one is in.
  task automatic push(input int v, input string tag);
    bus.i_val = 1'b1;
    bus.i_dat = WIDTH'(v);
    #1;
    chk({tag, "_irdy"}, 32'(bus.i_rdy), 1);
    chk({tag, "_clkena"}, 32'(bus.sr_clkena), 1);
    tick();
    bus.i_val = 1'b0;
  endtask

  initial begin
    reset       = 1'b1;
    bus.i_dat   = '0;
    bus.i_val   = 1'b0;
    bus.i_flush = 1'b0;
    bus.o_rdy   = 1'b1;
    #1;
    chk("rst_irdy", 32'(bus.i_rdy), 0);
    chk("rst_oval", 32'(bus.o_val), 0);
    repeat (2) tick();
    reset = 1'b0;
    #1;

    // 1: idle after reset
    chk("s1_oval", 32'(bus.o_val), 0);
    chk("s1_primed", 32'(bus.o_primed), 0);
    chk("s1_busy", 32'(bus.o_busy), 0);
    chk("s1_irdy", 32'(bus.i_rdy), 1);
    chk("s1_clkena", 32'(bus.sr_clkena), 0);
    chk_fill("s1_fill", 0);

    // 2: fill with 1..6
    for (int k = 1; k <= FILL; k++) begin
      chk("s2_oval_pre", 32'(bus.o_val), 0);
      chk_fill("s2_fill", k - 1);
      push(k, "s2");
    end
    bus.i_val = 1'b1;
    bus.i_dat = 8'd7;
    bus.o_rdy = 1'b0;
    #1;
    chk("s2_oval", 32'(bus.o_val), 1);
    chk("s2_primed", 32'(bus.o_primed), 1);
    chk_taps("s2", 5, 3, 1, 1);
    chk_fill("s2_fill6", 6);

    // 3: backpressure holds the window
    for (int j = 0; j < 4; j++) begin
      chk("s3_irdy_hold", 32'(bus.i_rdy), 0);
      chk("s3_clkena_hold", 32'(bus.sr_clkena), 0);
      tick();
      chk("s3_oval_hold", 32'(bus.o_val), 1);
      chk_taps("s3_hold", 5, 3, 1, 1);
    end
    bus.o_rdy = 1'b1;
    #1;
    chk("s3_irdy", 32'(bus.i_rdy), 1);
    tick();
    bus.i_val = 1'b0;
    #1;
    chk("s3_oval", 32'(bus.o_val), 1);
    chk_taps("s3", 6, 4, 2, 2);
    chk_fill("s3_fill_sat", 6);

    // 4: flush beats a simultaneous sample
    bus.i_flush = 1'b1;
    bus.i_val   = 1'b1;
    bus.i_dat   = 8'd9;
    #1;
    chk("s4_irdy", 32'(bus.i_rdy), 0);
    chk("s4_clkena", 32'(bus.sr_clkena), 0);
    tick();
    bus.i_flush = 1'b0;
    bus.i_val   = 1'b0;
    #1;
    chk("s4_tap0_kept", 32'(tap(0)), 6);
    for (int c = 0; c < FILL; c++) begin
      chk("s4_busy", 32'(bus.o_busy), 1);
      chk("s4_fclkena", 32'(bus.sr_clkena), 1);
      chk("s4_fidat", 32'(bus.sr_idat), 0);
      chk("s4_foval", 32'(bus.o_val), 0);
      chk("s4_firdy", 32'(bus.i_rdy), 0);
      tick();
    end
    #1;
    chk("s4_busy_done", 32'(bus.o_busy), 0);
    chk("s4_primed", 32'(bus.o_primed), 0);
    chk("s4_oval", 32'(bus.o_val), 0);
    chk_taps("s4_zero", 0, 0, 0, 0);
    chk_fill("s4_fill", 0);
    for (int k = 10; k < 10 + FILL; k++) begin
      chk("s4_oval_pre", 32'(bus.o_val), 0);
      push(k, "s4");
    end
    #1;
    chk("s4_oval_refill", 32'(bus.o_val), 1);
    chk_taps("s4_refill", 14, 12, 10, 10);
    push(16, "s4_7th");
    #1;
    chk_fill("s4_fill_sat", 6);
    tick();
    chk("s4_oval_drain", 32'(bus.o_val), 0);
    chk("s4_primed_kept", 32'(bus.o_primed), 1);

    // 5: reset during flush cycle 3
    bus.i_flush = 1'b1;
    tick();
    bus.i_flush = 1'b0;
    tick();
    tick();
    chk("s5_busy_pre", 32'(bus.o_busy), 1);
    reset = 1'b1;
    #1;
    chk("s5_busy", 32'(bus.o_busy), 0);
    chk("s5_oval", 32'(bus.o_val), 0);
    chk("s5_primed", 32'(bus.o_primed), 0);
    chk("s5_irdy", 32'(bus.i_rdy), 0);
    chk("s5_clkena", 32'(bus.sr_clkena), 0);
    chk_fill("s5_fill", 0);
    tick();
    reset = 1'b0;
    #1;
    chk("s5_irdy_run", 32'(bus.i_rdy), 1);
    chk("s5_busy_run", 32'(bus.o_busy), 0);
    for (int k = 20; k < 20 + FILL; k++) begin
      chk("s5_oval_pre", 32'(bus.o_val), 0);
      push(k, "s5");
    end
    #1;
    chk("s5_oval_refill", 32'(bus.o_val), 1);
    chk_taps("s5_refill", 24, 22, 20, 20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
